// File: rtl/lcd_hex_writer_if.sv
// LCD pin bundle for the HD44780 8-bit write-only bus.
// The master drives the pins; the slave is the panel side.
interface lcd_hex_writer_if;
  logic       LCD_RS;
  logic       LCD_E;
  logic [7:0] LCD_D;

  modport master (output LCD_RS, output LCD_E, output LCD_D);
  modport slave  (input  LCD_RS, input  LCD_E, input  LCD_D);
endinterface

// File: rtl/lcd_hex_writer.sv
// Drives a 16x2 HD44780 LCD in 8-bit write-only mode, showing a (line 1) and b (line 2) as hex.
// Define LCD_DIFF_EN to hold after each frame until a or b changes.
module lcd_hex_writer #(
  parameter int unsigned NBITS     = 64,
  parameter int unsigned T_POWERUP = 2_500_000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EPULSE  = 25,
  parameter int unsigned T_CMD     = 2_500,
  parameter int unsigned T_CLEAR   = 100_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  lcd_hex_writer_if.master lcd,
  output logic             ready,
  output logic             frame_done
);
  localparam int unsigned NNib  = NBITS / 4;
  localparam int unsigned TMaxA = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int unsigned TMaxB = (T_CMD > T_EPULSE) ? T_CMD : T_EPULSE;
  localparam int unsigned TMaxC = (TMaxB > T_SETUP) ? TMaxB : T_SETUP;
  localparam int unsigned TMax  = (TMaxA > TMaxC) ? TMaxA : TMaxC;
  localparam int unsigned WaitW = (TMax > 1) ? $clog2(TMax) : 1;

  typedef enum logic [2:0] {
    StPwrWait, StInit, StL1Addr, StL1Data, StL2Addr, StL2Data, StFrameEnd
`ifdef LCD_DIFF_EN
    , StHold
`endif
  } main_e;

  typedef enum logic [1:0] {PhSetup, PhPulse, PhWait} phase_e;

  main_e            main_q, main_d;
  phase_e           phase_q, phase_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [3:0]       col_q, col_d;
  logic             rs_q, rs_d, e_q, e_d;
  logic [7:0]       d_q, d_d;
  logic             ready_q, ready_d, frame_done_q, frame_done_d;
  logic [NBITS-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic             load, wait_done;
  int unsigned      lim;

  function automatic logic [7:0] hex_char(logic [NBITS-1:0] v, logic [3:0] col);
    logic [3:0] nib;
    if (32'(col) >= NNib) return 8'h20;
    nib = 4'(v >> (4 * (NNib - 1 - 32'(col))));
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // {RS, D} for the byte a given state/column sends.
  function automatic logic [8:0] byte_for(main_e st, logic [3:0] col,
                                          logic [NBITS-1:0] sa, logic [NBITS-1:0] sb);
    case (st)
      StInit: begin
        case (col[1:0])
          2'd0:    return 9'h038;
          2'd1:    return 9'h00C;
          2'd2:    return 9'h006;
          default: return 9'h001;
        endcase
      end
      StL1Addr: return 9'h080;
      StL2Addr: return 9'h0C0;
      StL1Data: return {1'b1, hex_char(sa, col)};
      StL2Data: return {1'b1, hex_char(sb, col)};
      default:  return 9'h000;
    endcase
  endfunction

  always_comb begin
    lim = T_CMD;
    if (main_q == StPwrWait) begin
      lim = T_POWERUP;
    end else begin
      case (phase_q)
        PhSetup: lim = T_SETUP;
        PhPulse: lim = T_EPULSE;
        default: lim = (!rs_q && d_q == 8'h01) ? T_CLEAR : T_CMD;
      endcase
    end
  end

  assign wait_done = (32'(wait_q) + 32'd1 == lim);

  always_comb begin
    main_d       = main_q;
    phase_d      = phase_q;
    wait_d       = wait_q + WaitW'(1);
    col_d        = col_q;
    rs_d         = rs_q;
    d_d          = d_q;
    e_d          = e_q;
    ready_d      = ready_q;
    frame_done_d = 1'b0;
    snap_a_d     = snap_a_q;
    snap_b_d     = snap_b_q;
    load         = 1'b0;

    unique case (main_q)
      StPwrWait: begin
        if (wait_done) begin
          main_d = StInit;
          col_d  = '0;
          load   = 1'b1;
        end
      end
      StFrameEnd: begin
        wait_d = '0;
`ifdef LCD_DIFF_EN
        main_d = StHold;
`else
        main_d = StL1Addr;
        load   = 1'b1;
`endif
      end
`ifdef LCD_DIFF_EN
      StHold: begin
        wait_d = '0;
        if (a != snap_a_q || b != snap_b_q) begin
          main_d = StL1Addr;
          load   = 1'b1;
        end
      end
`endif
      default: begin
        unique case (phase_q)
          PhSetup: if (wait_done) begin
            phase_d = PhPulse;
            e_d     = 1'b1;
            wait_d  = '0;
          end
          PhPulse: if (wait_done) begin
            phase_d = PhWait;
            e_d     = 1'b0;
            wait_d  = '0;
          end
          default: if (wait_done) begin
            load   = 1'b1;
            wait_d = '0;
            case (main_q)
              StInit: begin
                if (col_q == 4'd3) begin
                  main_d  = StL1Addr;
                  ready_d = 1'b1;
                end else begin
                  col_d = col_q + 4'd1;
                end
              end
              StL1Addr: begin
                main_d = StL1Data;
                col_d  = '0;
              end
              StL1Data: begin
                if (col_q == 4'd15) main_d = StL2Addr;
                else                col_d  = col_q + 4'd1;
              end
              StL2Addr: begin
                main_d = StL2Data;
                col_d  = '0;
              end
              StL2Data: begin
                if (col_q == 4'd15) begin
                  main_d       = StFrameEnd;
                  frame_done_d = 1'b1;
                  load         = 1'b0;
                end else begin
                  col_d = col_q + 4'd1;
                end
              end
              default: ;
            endcase
          end
        endcase
      end
    endcase

    // Every frame starts from one coherent (a, b) pair.
    if (main_d == StL1Addr && main_q != StL1Addr) begin
      snap_a_d = a;
      snap_b_d = b;
    end

    if (load) begin
      phase_d      = PhSetup;
      wait_d       = '0;
      {rs_d, d_d}  = byte_for(main_d, col_d, snap_a_d, snap_b_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_q       <= StPwrWait;
      phase_q      <= PhSetup;
      wait_q       <= '0;
      col_q        <= '0;
      rs_q         <= 1'b0;
      d_q          <= 8'h00;
      e_q          <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      snap_a_q     <= '0;
      snap_b_q     <= '0;
    end else begin
      main_q       <= main_d;
      phase_q      <= phase_d;
      wait_q       <= wait_d;
      col_q        <= col_d;
      rs_q         <= rs_d;
      d_q          <= d_d;
      e_q          <= e_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
    end
  end

  assign lcd.LCD_RS = rs_q;
  assign lcd.LCD_E  = e_q;
  assign lcd.LCD_D  = d_q;
  assign ready      = ready_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_hex_writer.sv
// Scoreboard bench for lcd_hex_writer: stimulus pushes expected bytes, a pin monitor
// pops them on each E fall and checks bus timing.
module tb_lcd_hex_writer;
  localparam int unsigned NBITS     = 64;
  localparam int unsigned T_POWERUP = 100;
  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_EPULSE  = 3;
  localparam int unsigned T_CMD     = 10;
  localparam int unsigned T_CLEAR   = 40;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [NBITS-1:0] a, b;
  logic             ready, frame_done;

  lcd_hex_writer_if lcd_if ();

  lcd_hex_writer #(
    .NBITS(NBITS), .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP),
    .T_EPULSE(T_EPULSE), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .lcd(lcd_if),
    .ready(ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         n_rise = 0;
  logic [8:0] sb[$];
  logic       mon_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: nibble NBITS/4-1-k in column k, upper-case hex, spaces past the value.
  function automatic logic [7:0] model_char(logic [NBITS-1:0] v, int k);
    logic [NBITS-1:0] t;
    int nib;
    if (k >= int'(NBITS / 4)) return 8'h20;
    t   = v >> (4 * (int'(NBITS / 4) - 1 - k));
    nib = int'(t[3:0]);
    return (nib < 10) ? 8'("0" + nib) : 8'("A" + nib - 10);
  endfunction

  task automatic push_init();
    sb.push_back(9'h038);
    sb.push_back(9'h00C);
    sb.push_back(9'h006);
    sb.push_back(9'h001);
  endtask

  task automatic push_frame(input logic [NBITS-1:0] va, input logic [NBITS-1:0] vb);
    sb.push_back(9'h080);
    for (int k = 0; k < 16; k++) sb.push_back({1'b1, model_char(va, k)});
    sb.push_back(9'h0C0);
    for (int k = 0; k < 16; k++) sb.push_back({1'b1, model_char(vb, k)});
  endtask

  // Monitor state
  logic       rst_at_edge, e_prev, ready_prev, fd_prev, have_fall, first_rise_pend;
  logic [8:0] bus, bus_prev, fall_bus, exp_b;
  int         e_cnt, fall_cyc, last_change, rst_cyc, data_since_c0, dcy, gap;

  always @(posedge clk) begin
    rst_at_edge = reset_n;
    cyc++;
    #1;
    bus = {lcd_if.LCD_RS, lcd_if.LCD_D};
    if (!rst_at_edge) begin
      rst_cyc = cyc;  have_fall = 1'b0;  first_rise_pend = 1'b1;  e_cnt = 0;
      e_prev = 1'b0;  ready_prev = 1'b0;  fd_prev = 1'b0;  data_since_c0 = 0;
      bus_prev = bus; last_change = cyc;
    end else begin
      if (!lcd_if.LCD_E && e_prev) begin
        chk("e_width", 64'(e_cnt), 64'(T_EPULSE));
        if (mon_en) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h, expected none (cycle %0d)", bus, cyc);
          end else begin
            exp_b = sb.pop_front();
            chk("byte", 64'(bus), 64'(exp_b));
          end
        end
        data_since_c0 = bus[8] ? data_since_c0 + 1 : 0;
        fall_cyc  = cyc;
        fall_bus  = bus;
        have_fall = 1'b1;
      end
      if (bus != bus_prev) begin
        if (lcd_if.LCD_E) chk("bus_during_e", 64'(bus), 64'(bus_prev));
        if (have_fall) begin
          gap = (fall_bus == 9'h001) ? int'(T_CLEAR) : int'(T_CMD);
          dcy = cyc - fall_cyc;
          chk("hold_after_fall", 64'((dcy >= gap) ? gap : dcy), 64'(gap));
        end
        have_fall   = 1'b0;
        last_change = cyc;
      end
      if (lcd_if.LCD_E && !e_prev) begin
        n_rise++;
        dcy = cyc - last_change;
        chk("setup", 64'((dcy >= int'(T_SETUP)) ? int'(T_SETUP) : dcy), 64'(T_SETUP));
        if (first_rise_pend) chk("pwr_wait", 64'(cyc - rst_cyc), 64'(T_POWERUP + T_SETUP));
        first_rise_pend = 1'b0;
        e_cnt = 1;
      end else if (lcd_if.LCD_E) begin
        e_cnt++;
      end
      if (ready && !ready_prev) chk("ready_gap", 64'(cyc - fall_cyc), 64'(T_CLEAR));
      if (ready_prev) chk("ready_hold", 64'(ready), 64'd1);
      if (frame_done) begin
        chk("fd_width", 64'(fd_prev), 64'd0);
        chk("fd_after_line2", 64'(data_since_c0), 64'd16);
      end
      bus_prev = bus;
    end
    e_prev     = lcd_if.LCD_E;
    ready_prev = ready;
    fd_prev    = frame_done;
  end

  task automatic wait_rises(input int n);
    int target = n_rise + n;
    int budget = 2000;
    while (n_rise < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (n_rise < target) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_rises: got %0d rises, expected %0d", n_rise, target);
    end
  endtask

  task automatic wait_frame_done();
    int budget = 3000;
    do begin
      @(negedge clk);
      budget--;
    end while (!frame_done && budget > 0);
    if (!frame_done) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_frame_done: got no pulse, expected one within 3000 cycles");
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_e", 64'(lcd_if.LCD_E), 64'd0);
    chk("rst_rs", 64'(lcd_if.LCD_RS), 64'd0);
    chk("rst_d", 64'(lcd_if.LCD_D), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NBITS-1:0] a_old, b_old;
    int budget;
    int r0;
    a = 64'h0123456789ABCDEF;
    b = 64'hFEDCBA9876543210;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    push_init();
    push_frame(a, b);
    reset_n = 1'b1;

    // Values change mid-frame; the next frame must show them, the current one must not.
    for (int k = 0; k < 5; k++) begin
      wait_rises(6);
      a_old = a;
      b_old = b;
      if (k == 0) begin
        a = '0;
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if (a == a_old && b == b_old) a = ~a;
      end
      push_frame(a, b);
      wait_frame_done();
    end
    wait_frame_done();

    // Start another frame, then reset in the middle of its first E pulse.
    a = {$urandom, $urandom} | 64'h1;
    a[0] = ~a[0] ^ ~a_old[0];
    if (a == a_old) a = ~a;
    push_frame(a, b);
    budget = 200;
    while (!lcd_if.LCD_E && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("e_high_before_reset", 64'(lcd_if.LCD_E), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    sb.delete();
    push_init();
    push_frame(a, b);
    reset_n = 1'b1;
    wait_frame_done();

`ifdef LCD_DIFF_EN
    r0 = n_rise;
    repeat (5000) @(negedge clk);
    chk("hold_quiet", 64'(n_rise - r0), 64'd0);
    b[3:0] = b[3:0] ^ 4'h1;
    push_frame(a, b);
    r0 = n_rise;
    wait_frame_done();
    chk("one_frame", 64'(n_rise - r0), 64'd34);
`else
    r0 = n_rise;
`endif

    mon_en = 1'b0;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
